// File: rtl/tug_round_ctrl_if.sv
// tug_round_ctrl_if: start/press inputs and round-result/display outputs of the round sequencer.
interface tug_round_ctrl_if;
  logic start_i, pbl_i, pbr_i;
  logic clear_o, leds_on_o, winrnd_o, right_o, tie_o, false_start_o, busy_o;
  logic [1:0] led_control_o;
  modport master (
    output start_i, pbl_i, pbr_i,
    input  clear_o, leds_on_o, winrnd_o, right_o, tie_o, false_start_o, busy_o, led_control_o
  );
  modport slave (
    input  start_i, pbl_i, pbr_i,
    output clear_o, leds_on_o, winrnd_o, right_o, tie_o, false_start_o, busy_o, led_control_o
  );
endinterface

// File: rtl/tug_round_ctrl.sv
// tug_round_ctrl: tug-of-war round sequencer (random ready delay, armed window with timeout, result hold).
// Define TUG_FALSE_START_EN to end the round on a press during the ready delay.
module tug_round_ctrl #(
  parameter int DELAY_MIN = 4,
  parameter int DELAY_W   = 3,
  parameter int TIMEOUT   = 10,
  parameter int HOLD_CYC  = 3
) (
  input logic             clk,
  input logic             rst_n,
  tug_round_ctrl_if.slave bus
);
  localparam int DMAX = DELAY_MIN + (1 << DELAY_W) - 1;
  localparam int TMAX = DMAX > TIMEOUT ? DMAX : TIMEOUT;
  localparam int CMAX = TMAX > HOLD_CYC ? TMAX : HOLD_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  // encoding doubles as the led_control display select
  typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, ARMED = 2'b10, HOLD = 2'b11} state_t;
  state_t        state_q, state_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          win_q, win_d, right_q, right_d, tie_q, tie_d, fs_q, fs_d;
  logic          clear_q, leds_q, busy_q;
  logic [1:0]    lc_q;
  logic          press, both, last;
  assign press  = bus.pbl_i | bus.pbr_i;
  assign both   = bus.pbl_i & bus.pbr_i;
  assign last   = cnt_q == CW'(1);
  assign lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = 1'b0;
    right_d = right_q;
    tie_d   = 1'b0;
    fs_d    = 1'b0;
    case (state_q)
      IDLE: if (bus.start_i) begin
        state_d = WAIT;
        cnt_d   = CW'(DELAY_MIN) + CW'(lfsr_q[DELAY_W-1:0]);
      end
      WAIT: begin
`ifdef TUG_FALSE_START_EN
        if (press) begin
          state_d = HOLD;
          cnt_d   = CW'(HOLD_CYC);
          fs_d    = 1'b1;
          tie_d   = both;
          win_d   = !both;
          right_d = both ? right_q : bus.pbl_i;
        end else
`endif
        if (last) begin
          state_d = ARMED;
          cnt_d   = CW'(TIMEOUT);
        end else cnt_d = cnt_q - CW'(1);
      end
      ARMED: begin
        // a press on the final armed edge beats the timeout
        if (press || last) begin
          state_d = HOLD;
          cnt_d   = CW'(HOLD_CYC);
          tie_d   = both || !press;
          win_d   = press && !both;
          right_d = (press && !both) ? bus.pbr_i : right_q;
        end else cnt_d = cnt_q - CW'(1);
      end
      default: begin
        if (last) state_d = IDLE;
        else cnt_d = cnt_q - CW'(1);
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= 8'hA5;
      cnt_q   <= '0;
      win_q   <= 1'b0;
      right_q <= 1'b0;
      tie_q   <= 1'b0;
      fs_q    <= 1'b0;
      clear_q <= 1'b1;
      leds_q  <= 1'b0;
      busy_q  <= 1'b0;
      lc_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      right_q <= right_d;
      tie_q   <= tie_d;
      fs_q    <= fs_d;
      clear_q <= state_d == IDLE;
      leds_q  <= state_d == ARMED;
      busy_q  <= state_d != IDLE;
      lc_q    <= 2'(state_d);
    end
  end
  assign bus.clear_o       = clear_q;
  assign bus.leds_on_o     = leds_q;
  assign bus.winrnd_o      = win_q;
  assign bus.right_o       = right_q;
  assign bus.tie_o         = tie_q;
  assign bus.false_start_o = fs_q;
  assign bus.busy_o        = busy_q;
  assign bus.led_control_o = lc_q;
endmodule

// File: tb/tb_tug_round_ctrl.sv
// tb_tug_round_ctrl: randomized rounds checked by a scoreboard of expected arm/result/idle events.
module tb_tug_round_ctrl;
  localparam int DMIN = 4, DW = 3, TO = 10, HC = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic [7:0] m_lfsr;
  bit exp_right = 1'b0;
  typedef struct {int kind; int cyc; int res;} ev_t;
  ev_t sb[$];
  tug_round_ctrl_if bus();
  tug_round_ctrl #(.DELAY_MIN(DMIN), .DELAY_W(DW), .TIMEOUT(TO), .HOLD_CYC(HC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n)
    m_lfsr <= !rst_n ? 8'hA5 : ({1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00));

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_reset(string nm);
    chk(nm, int'({bus.clear_o, bus.busy_o, bus.led_control_o, bus.leds_on_o, bus.winrnd_o,
                  bus.right_o, bus.tie_o, bus.false_start_o}), 9'h100);
  endtask

  task automatic pop_chk(int kind);
    ev_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
      return;
    end
    e = sb.pop_front();
    chk("event_kind", kind, e.kind);
    chk("event_cycle", cyc, e.cyc);
    case (kind)
      0: chk("arm_led_control", int'(bus.led_control_o), 2);
      1: begin
        chk("result_flags", int'({bus.winrnd_o, bus.right_o, bus.tie_o, bus.false_start_o}), e.res);
        chk("result_led_control", int'(bus.led_control_o), 3);
      end
      default: chk("idle_clear_led", int'({bus.clear_o, bus.led_control_o}), 4);
    endcase
  endtask

  task automatic monitor();
    logic p_leds, p_busy;
    p_leds = 1'b0;
    p_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.leds_on_o && !p_leds) pop_chk(0);
        if (bus.winrnd_o || bus.tie_o) pop_chk(1);
        if (!bus.busy_o && p_busy) pop_chk(2);
      end
      p_leds = bus.leds_on_o;
      p_busy = bus.busy_o;
    end
  endtask

  // called just after a falling edge; start is sampled on the next rising edge
  task automatic round(bit rel_k, int off, bit pl, bit pr, bit stray);
    int k, a, j, res_e, end_e, s, n;
    bit has, arm, fs, w, t;
    k = cyc + 1;
    a = k + DMIN + int'(m_lfsr[DW-1:0]);
    j = rel_k ? k + off : a + off;
    has = pl || pr;
    arm = 1'b1;
    fs = 1'b0;
    res_e = a + TO;
    t = 1'b1;
    w = 1'b0;
    if (has && j > a && j <= a + TO) begin
      res_e = j;
      t = pl && pr;
      w = !t;
      if (w) exp_right = pr;
    end
`ifdef TUG_FALSE_START_EN
    if (has && j > k && j <= a) begin
      arm = 1'b0;
      fs = 1'b1;
      res_e = j;
      t = pl && pr;
      w = !t;
      if (w) exp_right = pl;
    end
`endif
    end_e = res_e + HC;
    if (arm) sb.push_back('{kind: 0, cyc: a, res: 0});
    sb.push_back('{kind: 1, cyc: res_e, res: int'({w, exp_right, t, fs})});
    sb.push_back('{kind: 2, cyc: end_e, res: 0});
    s = stray ? int'($urandom_range(k + 1, end_e)) : -1;
    bus.start_i = 1'b1;
    do begin
      @(negedge clk);
      n = cyc + 1;
      bus.start_i = n == s;
      bus.pbl_i = pl && n == j && n <= end_e;
      bus.pbr_i = pr && n == j && n <= end_e;
    end while (n <= end_e);
  endtask

  initial begin
    int k, a;
    bus.start_i = 1'b0;
    bus.pbl_i = 1'b0;
    bus.pbr_i = 1'b0;
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    #1 check_reset("reset_state");
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    round(0, 2, 0, 1, 0);
    round(0, 3, 1, 1, 0);
    round(0, 1, 0, 0, 0);
    round(0, 10, 1, 0, 0);
    round(1, 2, 1, 0, 0);
    round(1, 2, 1, 1, 0);
    round(0, 4, 1, 0, 1);
    round(1, 3, 0, 1, 1);
    for (int i = 0; i < 40; i++) begin
      bit rk;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rk = 1'($urandom_range(0, 1));
      round(rk, rk ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 13)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    k = cyc + 1;
    a = k + DMIN + int'(m_lfsr[DW-1:0]);
    sb.push_back('{kind: 0, cyc: a, res: 0});
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    while (cyc < a + 2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("mid_armed_reset");
    @(posedge clk);
    #1 check_reset("held_in_reset");
    sb.delete();
    exp_right = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    round(0, 1, 0, 1, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
